// File: rtl/contador_vagas_if.sv
// contador_vagas_if: sensor/status bundle for the parking-space counter.
//   V            raw asynchronous sensor bits, 1 = space free (master -> slave)
//   S            registered free-space count
//   Cheio        count is zero
//   Vazio        count equals N_VAGAS
//   Quase_cheio  count at or below the nearly-full threshold
//   Evento       one-cycle pulse on any count change
//   Ocupou       one-cycle pulse when the count drops
//   Liberou      one-cycle pulse when the count rises
interface contador_vagas_if #(
  parameter int N_VAGAS = 8
);
  localparam int W = $clog2(N_VAGAS + 1);

  logic [N_VAGAS-1:0] V;
  logic [W-1:0]       S;
  logic               Cheio;
  logic               Vazio;
  logic               Quase_cheio;
  logic               Evento;
  logic               Ocupou;
  logic               Liberou;

  modport master (
    output V,
    input  S, Cheio, Vazio, Quase_cheio, Evento, Ocupou, Liberou
  );

  modport slave (
    input  V,
    output S, Cheio, Vazio, Quase_cheio, Evento, Ocupou, Liberou
  );
endinterface

// File: rtl/contador_vagas.sv
// contador_vagas: counts free parking spaces from N_VAGAS occupancy sensors.
// Each sensor bit is synchronised (two flops), optionally debounced, then
// popcounted into a registered count S with registered status flags and
// one-cycle change pulses.
//
// Ports:
//   Clk  single clock, rising edge
//   Rst  asynchronous, active-high reset
//   bus  contador_vagas_if.slave (V in; S, flags and pulses out)
//
// Build option:
//   CONTADOR_VAGAS_DEBOUNCE_EN  when defined, each bit must disagree with its
//   filtered value for DEB_CICLOS consecutive cycles before it is accepted.
//   When undefined the synchronised bits feed the popcount directly and
//   DEB_CICLOS has no effect.
module contador_vagas #(
  parameter int N_VAGAS    = 8,
  parameter int DEB_CICLOS = 4,
  parameter int LIMIAR     = 1
) (
  input  logic                   Clk,
  input  logic                   Rst,
  contador_vagas_if.slave        bus
);
  localparam int W = $clog2(N_VAGAS + 1);
  localparam logic [W-1:0] LIMIAR_W  = W'(LIMIAR);
  localparam logic [W-1:0] N_VAGAS_W = W'(N_VAGAS);

  if (N_VAGAS < 1 || N_VAGAS > 255) begin : g_bad_n_vagas
    $error("contador_vagas: N_VAGAS must be 1..255");
  end
  if (DEB_CICLOS < 1 || DEB_CICLOS > 255) begin : g_bad_deb_ciclos
    $error("contador_vagas: DEB_CICLOS must be 1..255");
  end
  if (LIMIAR < 0 || LIMIAR > N_VAGAS) begin : g_bad_limiar
    $error("contador_vagas: LIMIAR must be 0..N_VAGAS");
  end

  logic [N_VAGAS-1:0] ff1_q, ff2_q;
  logic [N_VAGAS-1:0] f;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ff1_q <= '0;
      ff2_q <= '0;
    end else begin
      ff1_q <= bus.V;
      ff2_q <= ff1_q;
    end
  end

`ifdef CONTADOR_VAGAS_DEBOUNCE_EN
  localparam logic [7:0] DEB_MAX = 8'(DEB_CICLOS - 1);

  logic [N_VAGAS-1:0] f_q, f_d;
  logic [7:0]         cnt_q [N_VAGAS];
  logic [7:0]         cnt_d [N_VAGAS];

  // A counter only runs while its bit disagrees with the accepted value, so
  // any agreement (including a glitch ending) restarts the count.
  always_comb begin
    f_d = f_q;
    for (int i = 0; i < N_VAGAS; i++) begin
      cnt_d[i] = '0;
      if (ff2_q[i] != f_q[i]) begin
        if (cnt_q[i] == DEB_MAX) begin
          f_d[i] = ff2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      f_q <= '0;
      for (int i = 0; i < N_VAGAS; i++) cnt_q[i] <= '0;
    end else begin
      f_q <= f_d;
      for (int i = 0; i < N_VAGAS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign f = f_q;
`else
  assign f = ff2_q;
`endif

  logic [W-1:0] s_q, s_d;
  logic cheio_q, cheio_d, vazio_q, vazio_d, quase_q, quase_d;
  logic evento_q, evento_d, ocupou_q, ocupou_d, liberou_q, liberou_d;

  // Flags and pulses are derived from the next count so they line up with S
  // on the same edge. Simultaneous bit changes net out in the popcount, so
  // at most one of Ocupou/Liberou can fire.
  always_comb begin
    s_d = '0;
    for (int i = 0; i < N_VAGAS; i++) s_d = s_d + W'(f[i]);
    cheio_d   = (s_d == '0);
    vazio_d   = (s_d == N_VAGAS_W);
    quase_d   = (s_d <= LIMIAR_W);
    evento_d  = (s_d != s_q);
    ocupou_d  = (s_d < s_q);
    liberou_d = (s_d > s_q);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      s_q       <= '0;
      cheio_q   <= 1'b1;
      vazio_q   <= 1'b0;
      quase_q   <= 1'b1;
      evento_q  <= 1'b0;
      ocupou_q  <= 1'b0;
      liberou_q <= 1'b0;
    end else begin
      s_q       <= s_d;
      cheio_q   <= cheio_d;
      vazio_q   <= vazio_d;
      quase_q   <= quase_d;
      evento_q  <= evento_d;
      ocupou_q  <= ocupou_d;
      liberou_q <= liberou_d;
    end
  end

  assign bus.S           = s_q;
  assign bus.Cheio       = cheio_q;
  assign bus.Vazio       = vazio_q;
  assign bus.Quase_cheio = quase_q;
  assign bus.Evento      = evento_q;
  assign bus.Ocupou      = ocupou_q;
  assign bus.Liberou     = liberou_q;
endmodule

// File: tb/tb_contador_vagas.sv
// Self-checking bench for contador_vagas: default instance plus instances for
// LIMIAR=2, N_VAGAS=15 and N_VAGAS=16. Observations are packed as
// {S[7:0], Cheio, Vazio, Quase_cheio, Evento, Ocupou, Liberou}.
module tb_contador_vagas;
`ifdef CONTADOR_VAGAS_DEBOUNCE_EN
  localparam int DEB = 4;
  localparam int LAT = 2 + DEB;
`else
  localparam int LAT = 2;
`endif

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  contador_vagas_if #(.N_VAGAS(8))  bm ();
  contador_vagas_if #(.N_VAGAS(8))  bl ();
  contador_vagas_if #(.N_VAGAS(15)) b15 ();
  contador_vagas_if #(.N_VAGAS(16)) b16 ();

  contador_vagas #(.N_VAGAS(8))              dut_m  (.Clk(Clk), .Rst(Rst), .bus(bm.slave));
  contador_vagas #(.N_VAGAS(8), .LIMIAR(2))  dut_l  (.Clk(Clk), .Rst(Rst), .bus(bl.slave));
  contador_vagas #(.N_VAGAS(15))             dut_15 (.Clk(Clk), .Rst(Rst), .bus(b15.slave));
  contador_vagas #(.N_VAGAS(16))             dut_16 (.Clk(Clk), .Rst(Rst), .bus(b16.slave));

  wire [13:0] obs_m  = {8'(bm.S),  bm.Cheio,  bm.Vazio,  bm.Quase_cheio,  bm.Evento,  bm.Ocupou,  bm.Liberou};
  wire [13:0] obs_l  = {8'(bl.S),  bl.Cheio,  bl.Vazio,  bl.Quase_cheio,  bl.Evento,  bl.Ocupou,  bl.Liberou};
  wire [13:0] obs_15 = {8'(b15.S), b15.Cheio, b15.Vazio, b15.Quase_cheio, b15.Evento, b15.Ocupou, b15.Liberou};
  wire [13:0] obs_16 = {8'(b16.S), b16.Cheio, b16.Vazio, b16.Quase_cheio, b16.Evento, b16.Ocupou, b16.Liberou};

  int errors = 0;
  int checks = 0;
  logic [13:0] sb[$];

  function automatic logic [13:0] mk(int s, int prev, int n, int lim);
    logic [7:0] sv;
    sv = 8'(s);
    return {sv, 1'(s == 0), 1'(s == n), 1'(s <= lim), 1'(s != prev), 1'(s < prev), 1'(s > prev)};
  endfunction

  // Queue the expected per-cycle outputs for a count sequence, one entry per
  // clock edge after the stimulus.
  function automatic void push_seq(int seq[$], int prev0, int n, int lim);
    int prev;
    prev = prev0;
    foreach (seq[k]) begin
      sb.push_back(mk(seq[k], prev, n, lim));
      prev = seq[k];
    end
  endfunction

  function automatic void push_step(int old_s, int new_s, int n, int lim);
    int seq[$];
    for (int k = 0; k < LAT + 2; k++) seq.push_back(k >= LAT ? new_s : old_s);
    push_seq(seq, old_s, n, lim);
  endfunction

  task automatic test_reset();
    logic [13:0] e;
    @(negedge Clk);
    e = mk(0, 0, 8, 1);
    checks++;
    if (obs_m !== e) begin
      errors++;
      $display("FAIL reset_state got=%h want=%h", obs_m, e);
    end
    Rst = 1'b0;
  endtask

  task automatic test_fill();
    logic [13:0] e;
    bm.V = 8'hFF;
    push_step(0, 8, 8, 1);
    while (sb.size() > 0) begin
      @(negedge Clk);
      e = sb.pop_front();
      checks++;
      if (obs_m !== e) begin
        errors++;
        $display("FAIL fill got=%h want=%h", obs_m, e);
      end
    end
  endtask

  task automatic test_empty();
    logic [13:0] e;
    bm.V = 8'h00;
    push_step(8, 0, 8, 1);
    while (sb.size() > 0) begin
      @(negedge Clk);
      e = sb.pop_front();
      checks++;
      if (obs_m !== e) begin
        errors++;
        $display("FAIL empty got=%h want=%h", obs_m, e);
      end
    end
  endtask

  task automatic test_multi_bit();
    logic [13:0] e;
    logic [7:0] pat [3] = '{8'h1F, 8'h03, 8'h0C};
    int cnt [3] = '{5, 2, 2};
    int prev = 0;
    for (int p = 0; p < 3; p++) begin
      bm.V = pat[p];
      push_step(prev, cnt[p], 8, 1);
      prev = cnt[p];
      while (sb.size() > 0) begin
        @(negedge Clk);
        e = sb.pop_front();
        checks++;
        if (obs_m !== e) begin
          errors++;
          $display("FAIL multi_bit[%0d] got=%h want=%h", p, obs_m, e);
        end
      end
    end
  endtask

  // Three-cycle pulse on V[4] starting from S=2.
  task automatic test_glitch();
    logic [13:0] e;
    int seq[$];
`ifdef CONTADOR_VAGAS_DEBOUNCE_EN
    seq = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 2};
`else
    seq = '{2, 2, 3, 3, 3, 2, 2, 2};
`endif
    push_seq(seq, 2, 8, 1);
    bm.V = 8'h1C;
    for (int k = 0; sb.size() > 0; k++) begin
      @(negedge Clk);
      e = sb.pop_front();
      checks++;
      if (obs_m !== e) begin
        errors++;
        $display("FAIL glitch[%0d] got=%h want=%h", k, obs_m, e);
      end
      if (k == 2) bm.V = 8'h0C;
    end
  endtask

  task automatic test_reset_mid();
    logic [13:0] e;
    bm.V = 8'h1F;
    push_step(2, 5, 8, 1);
    while (sb.size() > 0) begin
      @(negedge Clk);
      e = sb.pop_front();
      checks++;
      if (obs_m !== e) begin
        errors++;
        $display("FAIL reset_mid_pre got=%h want=%h", obs_m, e);
      end
    end
    bm.V = 8'h3F;
    repeat (4) @(negedge Clk);
    Rst = 1'b1;
    #1;
    e = mk(0, 0, 8, 1);
    checks++;
    if (obs_m !== e) begin
      errors++;
      $display("FAIL reset_mid_async got=%h want=%h", obs_m, e);
    end
    @(negedge Clk);
    Rst = 1'b0;
    push_step(0, 6, 8, 1);
    while (sb.size() > 0) begin
      @(negedge Clk);
      e = sb.pop_front();
      checks++;
      if (obs_m !== e) begin
        errors++;
        $display("FAIL reset_mid_post got=%h want=%h", obs_m, e);
      end
    end
  endtask

  task automatic test_limiar();
    logic [13:0] e;
    logic [7:0] pat [3] = '{8'h07, 8'h03, 8'h01};
    int prev = 0;
    for (int p = 0; p < 3; p++) begin
      bl.V = pat[p];
      push_step(prev, 3 - p, 8, 2);
      prev = 3 - p;
      while (sb.size() > 0) begin
        @(negedge Clk);
        e = sb.pop_front();
        checks++;
        if (obs_l !== e) begin
          errors++;
          $display("FAIL limiar[%0d] got=%h want=%h", p, obs_l, e);
        end
      end
    end
  endtask

  task automatic test_width();
    logic [13:0] e;
    b15.V = '1;
    push_step(0, 15, 15, 1);
    while (sb.size() > 0) begin
      @(negedge Clk);
      e = sb.pop_front();
      checks++;
      if (obs_15 !== e) begin
        errors++;
        $display("FAIL width15 got=%h want=%h", obs_15, e);
      end
    end
    b16.V = '1;
    push_step(0, 16, 16, 1);
    while (sb.size() > 0) begin
      @(negedge Clk);
      e = sb.pop_front();
      checks++;
      if (obs_16 !== e) begin
        errors++;
        $display("FAIL width16 got=%h want=%h", obs_16, e);
      end
    end
  endtask

  initial begin
    bm.V = '0;
    bl.V = '0;
    b15.V = '0;
    b16.V = '0;
    Rst = 1'b1;
    repeat (2) @(negedge Clk);
    test_reset();
    test_fill();
    test_empty();
    test_multi_bit();
    test_glitch();
    test_reset_mid();
    test_limiar();
    test_width();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
